// File: rtl/eth_pkg.sv
// eth_pkg: shared encodings and default constants for the Ethernet TX
// scheduler (frame-type select codes, scheduler states, flag/address defaults).
package eth_pkg;

    // Frame type presented to the TX engine on tx_sel.
    typedef logic [1:0] tx_sel_t;
    localparam tx_sel_t SEL_NONE  = 2'b00;
    localparam tx_sel_t SEL_ARP   = 2'b01;
    localparam tx_sel_t SEL_MOTOR = 2'b10;
    localparam tx_sel_t SEL_AD    = 2'b11;

    // Scheduler sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        GAP   = 2'b11
    } sched_state_t;

    // Default frame flags and read base addresses.
    localparam logic [31:0] FLAG_MOTOR_DEF = 32'hE1EC_0C0D;
    localparam logic [31:0] FLAG_AD_DEF    = 32'hAD86_86DA;
    localparam logic [31:0] ADDR_MOTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] ADDR_AD_DEF    = 32'h1000_0000;

    // Channel indices used by the motor/AD round-robin arbiter.
    localparam logic RR_MOTOR = 1'b0;
    localparam logic RR_AD    = 1'b1;

    // Data frames (motor, AD) take part in round-robin; ARP does not.
    function automatic logic sel_is_data(input tx_sel_t sel);
        return sel[1];
    endfunction

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// eth_tx_scheduler_if: frame handshake between the TX scheduler (master)
// and the UDP/ARP transmit engine (slave).
interface eth_tx_scheduler_if #(
    parameter int ADDR_W = 32
) ();
    import eth_pkg::*;

    logic              tx_start;  // one-cycle frame start pulse
    tx_sel_t           tx_sel;    // frame type, held for the whole frame
    logic [ADDR_W-1:0] tx_addr;   // read base address for the payload
    logic [31:0]       tx_flag;   // flag word inserted in the frame
    logic              tx_done;   // one-cycle pulse: frame fully sent
    logic              tx_abort;  // one-cycle pulse: frame abandoned

    modport master (
        output tx_start, tx_sel, tx_addr, tx_flag, tx_abort,
        input  tx_done
    );

    modport slave (
        input  tx_start, tx_sel, tx_addr, tx_flag, tx_abort,
        output tx_done
    );

endinterface

// File: rtl/eth_rr_arb2.sv
// eth_rr_arb2: two-way round-robin arbiter. The grant is combinational from
// the request vector and a registered last-served pointer; the pointer only
// moves when the owner reports that a granted frame has finished.
module eth_rr_arb2
    import eth_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] req_i,      // [0] motor, [1] AD
    input  logic       upd_i,      // a data frame finished (done or timeout)
    input  logic       upd_idx_i,  // channel that finished
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic last_q;
    logic last_d;

    // Grant selection: on a tie serve the channel that was not served last.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        gnt_valid_o = |req_i;
        gnt_idx_o   = RR_MOTOR;
        last_d      = last_q;
        if (&req_i) begin
            gnt_idx_o = ~last_q;
        end else if (req_i[1]) begin
            gnt_idx_o = RR_AD;
        end
        if (upd_i) begin
            last_d = upd_idx_i;
        end
    end

    // Last-served pointer; resets to AD so motor wins the first tie.
    always_ff @(posedge sys_clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (sys_rst) begin
            last_q <= RR_AD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: shares the UDP/ARP transmit engine between ARP replies
// (strict priority), motor frames and AD frames (round-robin). Each grant
// gets a one-cycle tx_start with address/flag context, a watchdog while the
// frame is in flight and an inter-frame gap afterwards.
// Optional feature macro: SCHED_STATS_EN adds four 16-bit wrapping counters
// (ARP/motor/AD completions and aborts) as extra output ports.
module eth_tx_scheduler
    import eth_pkg::*;
#(
    parameter int                          C_AXI_ADDR_WIDTH = 32,
    parameter logic [31:0]                 FLAG_MOTOR       = FLAG_MOTOR_DEF,
    parameter logic [31:0]                 FLAG_AD          = FLAG_AD_DEF,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] C_ADDR_MOTOR2ETH = C_AXI_ADDR_WIDTH'(ADDR_MOTOR_DEF),
    parameter logic [C_AXI_ADDR_WIDTH-1:0] C_ADDR_AD2ETH    = C_AXI_ADDR_WIDTH'(ADDR_AD_DEF),
    parameter int                          WATCH_DOG_WIDTH  = 12,
    parameter int                          IFG_CYCLES       = 12
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               trig_arp,
    input  logic               trig_package_rst,
    input  logic               motor_req,
    input  logic               ad_req,
    output logic               motor_ack,
    output logic               ad_ack,
    output logic               sched_busy,
    eth_tx_scheduler_if.master tx_if
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]        stat_arp_cnt,
    output logic [15:0]        stat_motor_cnt,
    output logic [15:0]        stat_ad_cnt,
    output logic [15:0]        stat_abort_cnt
`endif
);

    // Gap counter counts 0 .. IFG_CYCLES-1; a zero or one cycle gap still
    // spends a single cycle in GAP.
    localparam int               GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (IFG_CYCLES > 1) ? GAP_W'(IFG_CYCLES - 1) : '0;

    sched_state_t                state_q,     state_d;
    logic                        arp_pend_q,  arp_pend_d;
    tx_sel_t                     sel_q,       sel_d;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [31:0]                 flag_q,      flag_d;
    logic                        start_q,     start_d;
    logic                        abort_q,     abort_d;
    logic                        motor_ack_q, motor_ack_d;
    logic                        ad_ack_q,    ad_ack_d;
    logic [WATCH_DOG_WIDTH-1:0]  wd_q,        wd_d;
    logic [GAP_W-1:0]            gap_q,       gap_d;

    logic gnt_valid;
    logic gnt_idx;
    logic rr_upd;
    logic rr_upd_idx;
    logic wd_expired;

    assign wd_expired = (wd_q == '1);
    assign rr_upd_idx = (sel_q == SEL_AD);

    // Motor/AD round-robin; ARP priority is resolved here in IDLE.
    eth_rr_arb2 u_rr_arb (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_i       ({ad_req, motor_req}),
        .upd_i       (rr_upd),
        .upd_idx_i   (rr_upd_idx),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // Next-state and output decode for the IDLE/START/WAIT/GAP sequencer.
    always_comb begin
        state_d     = state_q;
        arp_pend_d  = arp_pend_q | trig_arp;
        sel_d       = sel_q;
        addr_d      = addr_q;
        flag_d      = flag_q;
        start_d     = 1'b0;
        abort_d     = 1'b0;
        motor_ack_d = 1'b0;
        ad_ack_d    = 1'b0;
        wd_d        = wd_q;
        gap_d       = gap_q;
        rr_upd      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arp_pend_q) begin
                    // The pending flag is consumed by the grant that launches
                    // the ARP tx_start; a trig_arp in this or any later cycle
                    // queues another reply.
                    state_d    = START;
                    sel_d      = SEL_ARP;
                    addr_d     = '0;
                    flag_d     = '0;
                    arp_pend_d = trig_arp;
                end else if (gnt_valid) begin
                    state_d = START;
                    if (gnt_idx == RR_AD) begin
                        sel_d  = SEL_AD;
                        addr_d = C_ADDR_AD2ETH;
                        flag_d = FLAG_AD;
                    end else begin
                        sel_d  = SEL_MOTOR;
                        addr_d = C_ADDR_MOTOR2ETH;
                        flag_d = FLAG_MOTOR;
                    end
                end
            end

            START: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = WAIT;
            end

            WAIT: begin
                wd_d = wd_q + 1'b1;
                // Completion takes precedence over a simultaneous timeout.
                if (tx_if.tx_done || wd_expired) begin
                    motor_ack_d = tx_if.tx_done && (sel_q == SEL_MOTOR);
                    ad_ack_d    = tx_if.tx_done && (sel_q == SEL_AD);
                    abort_d     = !tx_if.tx_done;
                    rr_upd      = sel_is_data(sel_q);
                    state_d     = GAP;
                    gap_d       = '0;
                    sel_d       = SEL_NONE;
                    addr_d      = '0;
                    flag_d      = '0;
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Package reset overrides everything: drop queued ARP (including one
        // arriving now), abandon any frame in flight and restart the gap.
        if (trig_package_rst) begin
            arp_pend_d  = 1'b0;
            abort_d     = (state_q == START) || (state_q == WAIT);
            start_d     = 1'b0;
            motor_ack_d = 1'b0;
            ad_ack_d    = 1'b0;
            rr_upd      = 1'b0;
            state_d     = GAP;
            gap_d       = '0;
            sel_d       = SEL_NONE;
            addr_d      = '0;
            flag_d      = '0;
        end
    end

    // Sequencer state, frame context and registered output pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            arp_pend_q  <= 1'b0;
            sel_q       <= SEL_NONE;
            addr_q      <= '0;
            flag_q      <= '0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            motor_ack_q <= 1'b0;
            ad_ack_q    <= 1'b0;
            wd_q        <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            arp_pend_q  <= arp_pend_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            flag_q      <= flag_d;
            start_q     <= start_d;
            abort_q     <= abort_d;
            motor_ack_q <= motor_ack_d;
            ad_ack_q    <= ad_ack_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
        end
    end

    assign tx_if.tx_start = start_q;
    assign tx_if.tx_sel   = sel_q;
    assign tx_if.tx_addr  = addr_q;
    assign tx_if.tx_flag  = flag_q;
    assign tx_if.tx_abort = abort_q;
    assign motor_ack      = motor_ack_q;
    assign ad_ack         = ad_ack_q;
    assign sched_busy     = (state_q != IDLE);

`ifdef SCHED_STATS_EN
    logic [15:0] stat_arp_q;
    logic [15:0] stat_motor_q;
    logic [15:0] stat_ad_q;
    logic [15:0] stat_abort_q;
    logic        arp_done;

    assign arp_done = (state_q == WAIT) && tx_if.tx_done && (sel_q == SEL_ARP)
                      && !trig_package_rst;

    // Completion/abort counters; they wrap naturally at 16 bits.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stat_arp_q   <= '0;
            stat_motor_q <= '0;
            stat_ad_q    <= '0;
            stat_abort_q <= '0;
        end else begin
            if (arp_done)    stat_arp_q   <= stat_arp_q + 16'd1;
            if (motor_ack_d) stat_motor_q <= stat_motor_q + 16'd1;
            if (ad_ack_d)    stat_ad_q    <= stat_ad_q + 16'd1;
            if (abort_d)     stat_abort_q <= stat_abort_q + 16'd1;
        end
    end

    assign stat_arp_cnt   = stat_arp_q;
    assign stat_motor_cnt = stat_motor_q;
    assign stat_ad_cnt    = stat_ad_q;
    assign stat_abort_cnt = stat_abort_q;
`endif

endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
Sequences the UDP/ARP transmit engine by sharing it between three requesters: ARP reply, motor-data channel and AD-data channel.
- Latches requests and grants one at a time: ARP has strict priority; motor and AD alternate round-robin.
- For each grant it issues a one-cycle start with source-address and flag context, then waits for completion.
- A watchdog aborts hung frames, and an inter-frame gap is enforced between frames.
- Sits between the RX side (which raises trig_arp and trig_package_rst) and the TX engine.

Parameters:
- C_AXI_ADDR_WIDTH, 32, width of tx_addr
- FLAG_MOTOR, 32'hE1EC_0C0D, frame flag for motor frames
- FLAG_AD, 32'hAD86_86DA, frame flag for AD frames
- C_ADDR_MOTOR2ETH, 32'h0000_0000, read base address for motor frames
- C_ADDR_AD2ETH, 32'h1000_0000, read base address for AD frames
- WATCH_DOG_WIDTH, 12, watchdog counter width; timeout after 2^W-1 cycles in WAIT
- IFG_CYCLES, 12, idle cycles inserted after each frame (0 allowed)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active high
- trig_arp  in  1  one-cycle pulse: ARP reply required
- trig_package_rst  in  1  one-cycle pulse: abort current frame, clear all pending requests
- motor_req  in  1  level: motor data frame ready
- ad_req  in  1  level: AD data frame ready
- motor_ack  out  1  one-cycle pulse when a motor frame completes
- ad_ack  out  1  one-cycle pulse when an AD frame completes
- tx_start  out  1  one-cycle pulse: begin frame
- tx_sel  out  2  frame type: 00 none, 01 ARP, 10 motor, 11 AD; held from tx_start until done or abort
- tx_addr  out  C_AXI_ADDR_WIDTH  read base address for the frame (0 for ARP)
- tx_flag  out  32  flag word for the frame (0 for ARP)
- tx_done  in  1  one-cycle pulse from TX engine: frame sent
- tx_abort  out  1  one-cycle pulse: watchdog expired or package reset during WAIT
- sched_busy  out  1  high in any state other than IDLE

Interface (already decided): one clock, sys_clk. sys_rst is synchronous and active high.

Behaviour:
- Reset: all outputs 0, state IDLE, arp_pend 0, rr_last=AD (so motor wins the first tie), counters 0.
- arp_pend:
  - Set on trig_arp in any state.
  - Cleared on ARP tx_start.
  - A trig_arp arriving in the same cycle as an ARP tx_start keeps arp_pend set (a second reply is queued).
- Motor and AD requests:
  - Not latched; sampled in IDLE.
  - A requester must hold req until its ack.
- States:
  - IDLE: if arp_pend, grant ARP; else if motor_req and ad_req, grant the channel not equal to rr_last; else grant whichever is requesting. A grant goes to START the next cycle. tx_sel/addr/flag are registered on the grant.
  - START: tx_start=1 for exactly one cycle; clear watchdog; go to WAIT.
  - WAIT: watchdog increments each cycle.
    - On tx_done: pulse the matching ack (none for ARP); update rr_last (data channels only); go to GAP.
    - When the watchdog reaches all-ones: tx_abort=1; no ack; rr_last still updates; go to GAP.
  - GAP: count IFG_CYCLES cycles, clear tx_sel/addr/flag, then go to IDLE. With IFG_CYCLES=0, GAP lasts 1 cycle.
- Grant latency: request seen in IDLE -> tx_start 2 cycles later. tx_done -> next tx_start takes at least IFG_CYCLES+3 cycles.
- trig_package_rst: highest priority, any state.
  - Clears arp_pend.
  - In START or WAIT, also pulses tx_abort.
  - Forces GAP (counter restarted).
  - A trig_arp in the same cycle is dropped.
- tx_done outside WAIT: ignored.
- tx_done and watchdog expiry in the same cycle: done wins, no abort.

Optional Feature:
SCHED_STATS_EN
- Defined: adds outputs stat_arp_cnt, stat_motor_cnt, stat_ad_cnt, stat_abort_cnt, each 16 bits.
  - The first three increment on the matching completion; stat_abort_cnt increments on tx_abort.
  - All four wrap at 16'hFFFF -> 0 and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package eth_pkg holds:
  - the tx_sel encoding constants (SEL_NONE/ARP/MOTOR/AD);
  - the state enum (IDLE, START, WAIT, GAP);
  - the default flag and address constants.
- Optional sub-module eth_rr_arb2: 2-way round-robin arbiter, combinational grant with a registered last-grant pointer. It is instantiated once for motor/AD; ARP priority stays in the top block.

Test Plan:
1. motor_req=1 only; tx_done 10 cycles after tx_start. Expect:
   - tx_start 2 cycles after req;
   - tx_sel=10, tx_addr=32'h0, tx_flag=32'hE1EC_0C0D;
   - motor_ack on the cycle after tx_done;
   - next tx_start no earlier than 15 cycles after tx_done (IFG_CYCLES=12).
2. motor_req and ad_req held high, tx_done each frame -> grants alternate motor, AD, motor, AD; AD frames show tx_addr=32'h1000_0000 and tx_flag=32'hAD86_86DA.
3. trig_arp pulse while a motor frame is in WAIT, with ad_req high -> after motor done and GAP, next grant is ARP (tx_sel=01, addr=0, flag=0); AD follows.
4. No tx_done after tx_start -> tx_abort exactly 4095 cycles into WAIT, no ack, return to IDLE after GAP, requester re-granted per round-robin.
5. trig_package_rst mid-WAIT with arp_pend set -> tx_abort pulse, arp_pend cleared, no ARP frame issued.
6. sys_rst asserted mid-WAIT -> next cycle: all outputs 0 and state IDLE; a held motor_req is re-granted afterwards.
